// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per CLK_DIV-cycle slot,
// frame-latched display value, optional hex digits and leading-zero blanking.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_DIV       = 50000,
    parameter int HEX_EN        = 1,
    parameter int ACTIVE_LOW_AN = 1,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (ACTIVE_LOW_AN != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_OFF  = 7'b1111111;

    logic [PRE_W-1:0]        prescaler_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [NUM_DIGITS-1:0]   dp_shadow_reg;

    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [IDX_W-1:0]        digit_idx_reg;
    logic                    frame_tick_reg;

    logic                    slot_end;
    logic                    frame_end;
    logic [IDX_W-1:0]        idx_next;
    logic [PRE_W-1:0]        prescaler_next;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_onehot;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = (HEX_EN != 0) ? 7'b0001000 : SEG_OFF;
            4'hB: s = (HEX_EN != 0) ? 7'b0000011 : SEG_OFF;
            4'hC: s = (HEX_EN != 0) ? 7'b1000110 : SEG_OFF;
            4'hD: s = (HEX_EN != 0) ? 7'b0100001 : SEG_OFF;
            4'hE: s = (HEX_EN != 0) ? 7'b0000110 : SEG_OFF;
            default: s = (HEX_EN != 0) ? 7'b0001110 : SEG_OFF;
        endcase
        return s;
    endfunction

    // zero_from[k]: nibble k and every nibble above it are zero
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi]       = shadow_reg[4*gi +: 4];
            assign zero_from[gi] = (shadow_reg[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        slot_end       = enable && (prescaler_reg == PRE_LAST);
        frame_end      = slot_end && (idx_reg == IDX_LAST);
        prescaler_next = (prescaler_reg == PRE_LAST) ? '0 : prescaler_reg + 1'b1;
        idx_next       = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        an_onehot      = NUM_DIGITS'(1) << idx_reg;
        seg_next       = decode(nib[idx_reg]);
        if (blank_lz && (idx_reg != '0) && zero_from[idx_reg]) begin
            seg_next = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg <= '0;
            idx_reg       <= '0;
            shadow_reg    <= '0;
            dp_shadow_reg <= '0;
        end else if (enable) begin
            prescaler_reg <= prescaler_next;
            if (slot_end) begin
                idx_reg <= idx_next;
            end
            // display value only changes at the frame boundary so a frame never tears
            if (frame_end) begin
                shadow_reg    <= value;
                dp_shadow_reg <= dp_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            an_reg         <= AN_IDLE;
            digit_idx_reg  <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            digit_idx_reg  <= idx_reg;
            frame_tick_reg <= frame_end;
            if (enable) begin
                seg_reg <= seg_next;
                dp_reg  <= ~dp_shadow_reg[idx_reg];
                an_reg  <= (ACTIVE_LOW_AN != 0) ? ~an_onehot : an_onehot;
            end else begin
                seg_reg <= SEG_OFF;
                dp_reg  <= 1'b1;
                an_reg  <= AN_IDLE;
            end
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign digit_idx  = digit_idx_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Parametrised, time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits. It is the multi-digit successor to the team's single-digit BCD decoder.
- Scans one digit per refresh slot and decodes that digit's nibble (BCD or hex).
- Optionally blanks leading zeros.
- Latches the display value once per frame so the display never shows a tear.
- Sits between the datapath and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
CLK_DIV, 50000, clk cycles per digit slot (>=1)
HEX_EN, 1, 1: nibbles 10-15 show A,b,C,d,E,F; 0: nibbles 10-15 are blank
ACTIVE_LOW_AN, 1, 1: the selected anode is driven 0; 0: the selected anode is driven 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
value  in  4*NUM_DIGITS  one nibble per digit; digit 0 = value[3:0] (least significant)
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_lz  in  1  1 = blank leading zero digits
enable  in  1  0 = display dark and scan frozen
seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
an  out  NUM_DIGITS  one-hot digit select, polarity set by ACTIVE_LOW_AN
digit_idx  out  clog2(NUM_DIGITS), min 1  index of the digit currently displayed
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (synchronous, active-high, dominates enable):
  - prescaler=0, idx=0, shadow=0;
  - seg=7'b1111111, dp=1, an=all inactive;
  - digit_idx=0, frame_tick=0.
  - Reset asserted mid-scan aborts the slot; the scan restarts at digit 0 after release.
- Prescaler:
  - With enable=1, counts 0..CLK_DIV-1 and wraps to 0.
  - The terminal count (CLK_DIV-1) is the "slot end".
  - CLK_DIV=1 gives a slot end every cycle.
- Digit index:
  - At slot end, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - NUM_DIGITS=1 keeps idx at 0.
- Frame boundary (slot end with idx==NUM_DIGITS-1), on the same edge:
  - shadow <= value;
  - dp_shadow <= dp_in;
  - frame_tick <= 1 for exactly one cycle.
  - Changes on value or dp_in between boundaries are not displayed until the next frame. Exception: blank_lz is used live.
- Output register, one cycle after idx changes:
  - seg, dp, an and digit_idx reflect idx;
  - an[idx] is active and all other anodes are inactive;
  - all outputs are registered, with no combinational path from inputs to pins.
- Decode of nibble n = shadow[4*idx+3 : 4*idx]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - HEX_EN=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110;
  - HEX_EN=0: 10-15 give 1111111.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked (seg=1111111) if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - dp = ~dp_shadow[idx] regardless of blanking.
- enable=0:
  - prescaler, idx and shadow hold;
  - next cycle: an all inactive, seg=1111111, dp=1, frame_tick=0.
  - On re-enable, scanning resumes from the held idx/prescaler; outputs are valid one cycle later.
- Slot width is exactly CLK_DIV cycles; frame period is NUM_DIGITS*CLK_DIV cycles.

Test Plan:
Common setup for all scenarios: NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW_AN=1.
1. Reset: assert rst for 3 cycles with enable=1 -> seg=1111111, dp=1, an=1111, frame_tick=0; after release, first frame_tick occurs 16 cycles later.
2. BCD scan: value=16'h1234, dp_in=4'b0100, blank_lz=0, run 2 frames -> each digit is held for 4 cycles:
   - an=1110 gives seg=0011001 (4);
   - an=1101 gives 0110000 (3);
   - an=1011 gives 0100100 (2) with dp=0;
   - an=0111 gives 1111001 (1);
   - frame_tick is a single-cycle pulse every 16 cycles.
3. Hex mode: HEX_EN=1 with value=16'hAbCF -> digits 0..3 show 0001110, 1000110, 0000011, 0001000. Rebuild with HEX_EN=0 -> all four digits show 1111111.
4. Leading zero: value=16'h0050, blank_lz=1 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000. value=0 -> only digit 0 is lit (1000000).
5. Tearing: change value from 16'h1111 to 16'h2222 while idx=1 -> the rest of the frame still shows 1111001; 2222 appears from the frame after the next frame_tick.
6. Enable and reset mid-scan:
   - drop enable during digit 2 for 10 cycles -> an=1111, seg=1111111, digit_idx stays 2; on re-enable, digit 2 finishes its remaining slot cycles;
   - rst pulsed during digit 3 -> next displayed digit is 0 after release.
